vga_sync_monitor: RTL and testbench

//  Sink end of the VGA link: observes vga_h_sync/vga_v_sync/vga_r/g/b as driven to the connector,

---
 rtl/vga_sync_monitor_pkg.sv | 30 +++
 rtl/vga_sync_monitor_if.sv | 33 +++
 rtl/vga_sync_monitor_sync_edge_detect.sv | 33 +++
 rtl/vga_sync_monitor.sv | 216 +++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_monitor_pkg.sv
// ============================================================================
// vga_sync_monitor_pkg : shared widths, FSM codes and helpers for the VGA sink
// rev 1.0
// ============================================================================
`default_nettype none

package vga_sync_monitor_pkg;

  localparam int CNT_W = 11;
  localparam int PIX_W = 10;
  localparam int ACC_W = 19;
  localparam int ERR_W = 8;

  localparam logic [1:0] ST_SEARCH  = 2'b00;
  localparam logic [1:0] ST_MEASURE = 2'b01;
  localparam logic [1:0] ST_LOCKED  = 2'b10;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_monitor_if.sv
// ============================================================================
// vga_sync_monitor_if : VGA connector-side signal bundle (syncs + colour bits)
// rev 1.0
// ============================================================================
`default_nettype none

interface vga_sync_monitor_if;

  logic vga_h_sync;
  logic vga_v_sync;
  logic vga_r;
  logic vga_g;
  logic vga_b;

  modport master (
    output vga_h_sync,
    output vga_v_sync,
    output vga_r,
    output vga_g,
    output vga_b
  );

  modport slave (
    input vga_h_sync,
    input vga_v_sync,
    input vga_r,
    input vga_g,
    input vga_b
  );

endinterface

`default_nettype wire

// File: rtl/vga_sync_monitor_sync_edge_detect.sv
// ============================================================================
// vga_sync_monitor_sync_edge_detect : two-flop sync stage, polarity fix, leading edge
// rev 1.0
// ============================================================================
`default_nettype none

module vga_sync_monitor_sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic lead_edge
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= sync_in ^ ACTIVE_LOW;
      r_s2 <= r_s1;
    end
  end

  assign lead_edge = r_s1 & ~r_s2;

endmodule

`default_nettype wire

// File: rtl/vga_sync_monitor.sv
// ============================================================================
// vga_sync_monitor : VGA sink-side timing checker, lock FSM and lit-pixel counter
// rev 1.0
// ============================================================================
`default_nettype none

module vga_sync_monitor
  import vga_sync_monitor_pkg::*;
#(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_OFFSET    = 144,
  parameter int V_OFFSET    = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_LOW    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset,
  vga_sync_monitor_if.slave vga,
  input  logic [PIX_W-1:0]  probe_x,
  input  logic [PIX_W-1:0]  probe_y,
  output logic              locked,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_x,
  output logic [PIX_W-1:0]  pix_y,
  output logic              frame_done,
  output logic [CNT_W-1:0]  line_len,
  output logic [CNT_W-1:0]  frame_lines,
  output logic [ACC_W-1:0]  r_cnt,
  output logic [ACC_W-1:0]  g_cnt,
  output logic [ACC_W-1:0]  b_cnt,
  output logic [2:0]        probe_rgb,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_sticky
);

  localparam logic [CNT_W-1:0] C_H_TOTAL   = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] C_V_TOTAL   = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] C_H_OFF     = CNT_W'(H_OFFSET);
  localparam logic [CNT_W-1:0] C_V_OFF     = CNT_W'(V_OFFSET);
  localparam logic [CNT_W-1:0] C_H_END     = CNT_W'(H_OFFSET + H_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_END     = CNT_W'(V_OFFSET + V_ACTIVE);
  localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(2 * H_TOTAL);
  localparam logic [PIX_W-1:0] C_H_OFF_PIX = PIX_W'(H_OFFSET);
  localparam logic [PIX_W-1:0] C_V_OFF_PIX = PIX_W'(V_OFFSET);
  localparam logic [3:0]       C_LOCK      = 4'(LOCK_FRAMES);

  logic             w_h_edge;
  logic             w_v_edge;
  rgb_t             r_rgb_s1;
  rgb_t             w_inc;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic [CNT_W-1:0] w_h_cur;
  logic [CNT_W-1:0] w_v_cur;
  logic [CNT_W-1:0] w_h_len;
  logic [CNT_W-1:0] w_v_len;
  logic [PIX_W-1:0] w_dx;
  logic [PIX_W-1:0] w_dy;
  logic             w_in_area;
  logic             w_line_bad;
  logic             w_frame_bad;
  logic             w_timeout;
  logic             w_violation;
  logic             w_probe_hit;
  logic [1:0]       r_state;
  logic [3:0]       r_good;
  logic             r_frame_bad;
  logic [ACC_W-1:0] r_acc_r;
  logic [ACC_W-1:0] r_acc_g;
  logic [ACC_W-1:0] r_acc_b;
  rgb_t             r_shadow;

  vga_sync_monitor_sync_edge_detect #(.ACTIVE_LOW(SYNC_LOW)) u_h_edge (
    .clk       (clk),
    .reset     (reset),
    .sync_in   (vga.vga_h_sync),
    .lead_edge (w_h_edge)
  );

  vga_sync_monitor_sync_edge_detect #(.ACTIVE_LOW(SYNC_LOW)) u_v_edge (
    .clk       (clk),
    .reset     (reset),
    .sync_in   (vga.vga_v_sync),
    .lead_edge (w_v_edge)
  );

  // Colour shares the s1 stage with the syncs so every output refers to one sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb_s1 <= '0;
    end else begin
      r_rgb_s1 <= {vga.vga_r, vga.vga_g, vga.vga_b};
    end
  end

  always_comb begin
    w_h_cur = w_h_edge ? '0 : sat_inc(r_h_cnt);
    if (w_v_edge) begin
      w_v_cur = '0;
    end else if (w_h_edge) begin
      w_v_cur = sat_inc(r_v_cnt);
    end else begin
      w_v_cur = r_v_cnt;
    end
  end

  assign w_h_len     = r_h_cnt + CNT_W'(1);
  assign w_v_len     = r_v_cnt + CNT_W'(1);
  assign w_line_bad  = w_h_edge && (w_h_len != C_H_TOTAL);
  assign w_frame_bad = w_v_edge && (w_v_len != C_V_TOTAL);
  assign w_timeout   = (w_h_cur == C_TIMEOUT);
  assign w_violation = w_line_bad | w_frame_bad | w_timeout;

  assign locked    = (r_state == ST_LOCKED);
  assign w_dx      = w_h_cur[PIX_W-1:0] - C_H_OFF_PIX;
  assign w_dy      = w_v_cur[PIX_W-1:0] - C_V_OFF_PIX;
  assign w_in_area = (w_h_cur >= C_H_OFF) && (w_h_cur < C_H_END) &&
                     (w_v_cur >= C_V_OFF) && (w_v_cur < C_V_END);
  assign pix_valid = locked & w_in_area;
  assign pix_x     = pix_valid ? w_dx : '0;
  assign pix_y     = pix_valid ? w_dy : '0;

  assign w_inc       = pix_valid ? r_rgb_s1 : '0;
  assign w_probe_hit = pix_valid && (pix_x == probe_x) && (pix_y == probe_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_state     <= ST_SEARCH;
      r_good      <= '0;
      r_frame_bad <= 1'b0;
      r_acc_r     <= '0;
      r_acc_g     <= '0;
      r_acc_b     <= '0;
      r_shadow    <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      r_cnt       <= '0;
      g_cnt       <= '0;
      b_cnt       <= '0;
      probe_rgb   <= '0;
      err_cnt     <= '0;
      err_sticky  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      r_h_cnt    <= w_h_cur;
      r_v_cnt    <= w_v_cur;
      frame_done <= 1'b0;
      if (w_h_edge) line_len <= w_h_len;
      if (w_v_edge) frame_lines <= w_v_len;

      case (r_state)
        ST_SEARCH: begin
          if (w_v_edge) begin
            r_state     <= ST_MEASURE;
            r_good      <= '0;
            r_frame_bad <= 1'b0;
          end
        end

        ST_MEASURE: begin
          if (w_v_edge) begin
            r_frame_bad <= 1'b0;
            if (r_frame_bad | w_line_bad | w_frame_bad) begin
              r_good <= '0;
            end else if (r_good + 4'd1 == C_LOCK) begin
              r_good  <= '0;
              r_state <= ST_LOCKED;
            end else begin
              r_good <= r_good + 4'd1;
            end
          end else if (w_line_bad) begin
            r_frame_bad <= 1'b1;
          end
        end

        ST_LOCKED: begin
          if (w_violation) begin
            // Partial-frame statistics are discarded; published counts keep the last full frame.
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            err_sticky <= 1'b1;
            r_state    <= ST_SEARCH;
            r_acc_r    <= '0;
            r_acc_g    <= '0;
            r_acc_b    <= '0;
            r_shadow   <= '0;
          end else if (w_v_edge) begin
            r_cnt      <= r_acc_r;
            g_cnt      <= r_acc_g;
            b_cnt      <= r_acc_b;
            probe_rgb  <= r_shadow;
            frame_done <= 1'b1;
            r_acc_r    <= {{(ACC_W-1){1'b0}}, w_inc.r};
            r_acc_g    <= {{(ACC_W-1){1'b0}}, w_inc.g};
            r_acc_b    <= {{(ACC_W-1){1'b0}}, w_inc.b};
            r_shadow   <= w_probe_hit ? r_rgb_s1 : '0;
          end else begin
            r_acc_r <= r_acc_r + {{(ACC_W-1){1'b0}}, w_inc.r};
            r_acc_g <= r_acc_g + {{(ACC_W-1){1'b0}}, w_inc.g};
            r_acc_b <= r_acc_b + {{(ACC_W-1){1'b0}}, w_inc.b};
            if (w_probe_hit) r_shadow <= r_rgb_s1;
          end
        end

        default: r_state <= ST_SEARCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
// ============================================================================
// tb_vga_sync_monitor : directed, table-driven bench for vga_sync_monitor (reduced timing)
// rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync_monitor;

  localparam int HT = 12;
  localparam int VT = 6;
  localparam int HO = 3;
  localparam int VO = 1;
  localparam int HA = 8;
  localparam int VA = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  probe_x, probe_y;
  logic        locked, pix_valid, frame_done, err_sticky;
  logic [9:0]  pix_x, pix_y;
  logic [10:0] line_len, frame_lines;
  logic [18:0] r_cnt, g_cnt, b_cnt;
  logic [2:0]  probe_rgb;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int cur_hc = -100, cur_vc = -100, prev_hc = -100, prev_vc = -100;
  int fd_cnt = 0, fd0 = 0;
  int pix_bad = 0, pix_seen = 0;
  logic pix_mon = 1'b0;
  logic exp_v;

  always #5 clk = ~clk;

  vga_sync_monitor_if vif ();

  vga_sync_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_OFFSET(HO), .V_OFFSET(VO),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_LOW(1'b1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .vga(vif),
    .probe_x(probe_x), .probe_y(probe_y),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_done(frame_done), .line_len(line_len), .frame_lines(frame_lines),
    .r_cnt(r_cnt), .g_cnt(g_cnt), .b_cnt(b_cnt), .probe_rgb(probe_rgb),
    .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  typedef struct {
    int         md;
    int         px;
    int         py;
    int         er;
    int         eg;
    int         eb;
    logic [2:0] ep;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [2:0] colour(input int m, input int x, input int y);
    case (m)
      1:       return {(x >= 5 && x <= 9 && y >= 2 && y <= 5), 2'b00};
      2:       return {1'b0, (x == 0 && y == 0), 1'b0};
      4:       return 3'b111;
      5:       return {((x % 2) == 0), (y == 3), (x == y)};
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Generator coordinates: pins for (hc,vc) are driven just after a rising edge.
  task automatic drive(input int hc, input int vc, input logic hs_act, input logic vs_act);
    @(posedge clk);
    #1;
    prev_hc = cur_hc;
    prev_vc = cur_vc;
    cur_hc  = hc;
    cur_vc  = vc;
    vif.vga_h_sync = ~hs_act;
    vif.vga_v_sync = ~vs_act;
    {vif.vga_r, vif.vga_g, vif.vga_b} = colour(mode, hc - HO, vc - VO);
  endtask

  task automatic gen_frame(input int lines, input int long_line);
    for (int v = 0; v < lines; v++)
      for (int h = 0; h < ((v == long_line) ? HT + 1 : HT); h++)
        drive(h, v, (h < 2), (v == 0 && h < 6));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(-100, -100, 1'b0, 1'b0);
  endtask

  // The DUT reports the previously driven coordinate one cycle later.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (pix_mon) begin
      exp_v = (prev_hc >= HO) && (prev_hc < HO + HA) && (prev_vc >= VO) && (prev_vc < VO + VA);
      if (exp_v) pix_seen++;
      if (pix_valid !== exp_v) pix_bad++;
      else if (exp_v && (pix_x !== 10'(prev_hc - HO) || pix_y !== 10'(prev_vc - VO))) pix_bad++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 0, 0,  0,  0,  3'b000};
    vecs[1] = '{1, 6, 2, 6,  0,  0,  3'b100};
    vecs[2] = '{2, 0, 0, 0,  1,  0,  3'b010};
    vecs[3] = '{2, 9, 0, 0,  1,  0,  3'b000};
    vecs[4] = '{4, 7, 3, 32, 32, 32, 3'b111};
    vecs[5] = '{5, 3, 3, 16, 8,  4,  3'b011};

    probe_x = '0;
    probe_y = '0;
    vif.vga_h_sync = 1'b1;
    vif.vga_v_sync = 1'b1;
    {vif.vga_r, vif.vga_g, vif.vga_b} = 3'b000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_line_len", line_len, 0);
    check("rst_r_cnt", r_cnt, 0);
    check("rst_pix_valid", pix_valid, 0);

    // Lock acquisition: first edge enters MEASURE, two clean frames lock.
    gen_frame(VT, -1);
    gen_frame(VT, -1);
    check("lock_pending", locked, 0);
    gen_frame(VT, -1);
    check("lock_up", locked, 1);
    check("line_len", line_len, HT);
    check("frame_lines", frame_lines, VT);
    check("no_early_done", fd_cnt, 0);
    check("err_clean", err_cnt, 0);

    pix_bad = 0;
    pix_seen = 0;
    pix_mon = 1'b1;
    gen_frame(VT, -1);
    pix_mon = 1'b0;
    check("pix_map_errors", pix_bad, 0);
    check("pix_valid_count", pix_seen, HA * VA);

    for (int i = 0; i < 6; i++) begin
      mode    = vecs[i].md;
      probe_x = 10'(vecs[i].px);
      probe_y = 10'(vecs[i].py);
      fd0     = fd_cnt;
      gen_frame(VT, -1);
      gen_frame(VT, -1);
      check($sformatf("v%0d_r_cnt", i), r_cnt, vecs[i].er);
      check($sformatf("v%0d_g_cnt", i), g_cnt, vecs[i].eg);
      check($sformatf("v%0d_b_cnt", i), b_cnt, vecs[i].eb);
      check($sformatf("v%0d_probe", i), probe_rgb, vecs[i].ep);
      check($sformatf("v%0d_pulses", i), fd_cnt - fd0, 2);
      check($sformatf("v%0d_locked", i), locked, 1);
    end

    // One 13-clock line while locked.
    mode = 0;
    gen_frame(VT, 2);
    check("stretch_err_cnt", err_cnt, 1);
    check("stretch_sticky", err_sticky, 1);
    check("stretch_unlock", locked, 0);
    fd0 = fd_cnt;
    gen_frame(VT, -1);
    gen_frame(VT, -1);
    check("relock_pending", locked, 0);
    gen_frame(VT, -1);
    check("relock", locked, 1);
    check("no_done_unlocked", fd_cnt - fd0, 0);
    check("relock_err_cnt", err_cnt, 1);

    // Hsync stall: timeout fires once h_cnt reaches 2*H_TOTAL.
    idle(10);
    check("stall_short_ok", err_cnt, 1);
    idle(18);
    check("timeout_err_cnt", err_cnt, 2);
    check("timeout_unlock", locked, 0);

    mode = 4;
    gen_frame(VT, -1);
    gen_frame(VT, -1);
    gen_frame(VT, -1);
    check("relock2", locked, 1);
    gen_frame(VT, -1);
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < HT; h++)
        drive(h, v, (h < 2), (v == 0 && h < 6));
    check("pre_rst_r_cnt", r_cnt, HA * VA);
    check("pre_rst_probe", probe_rgb, 3'b111);

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_locked", locked, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_sticky", err_sticky, 0);
    check("midrst_line_len", line_len, 0);
    check("midrst_frame_lines", frame_lines, 0);
    check("midrst_counts", {r_cnt, g_cnt, b_cnt} == '0, 1);
    check("midrst_probe", probe_rgb, 0);
    check("midrst_pix", {pix_valid, pix_x, pix_y, frame_done}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Repeated lock / short-frame violation cycles to saturate err_cnt.
    mode = 0;
    for (int i = 0; i < 260; i++) begin
      gen_frame(1, -1);
      gen_frame(VT, -1);
      gen_frame(VT, -1);
      gen_frame(1, -1);
      if (i == 10) check("err_cnt_mid", err_cnt, 10);
    end
    gen_frame(1, -1);
    check("err_cnt_sat", err_cnt, 255);
    check("err_sticky_sat", err_sticky, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
